// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared types and helpers for the multi-port register file
package rf_pkg;

  // Clear engine states
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } rf_state_e;

  // Ceiling log2, used to size address fields from the register count
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Low bit of the slice occupied by a port inside a flattened bus
  function automatic int slice_lo(input int port, input int width);
    return port * width;
  endfunction

  // Low bit of a register inside the flattened storage image
  function automatic int word_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// rtl/rf_read_port.sv - one read port: word selector plus zero-register and forwarding
module rf_read_port
  import rf_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic [NUM_REGS*DATA_W-1:0] mem_flat,
  input  logic [ADDR_W-1:0]          raddr,
  input  logic                       byp_en,
  input  logic [ADDR_W-1:0]          waddr,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          rdata
);

  logic [DATA_W-1:0] sel_word;

  // NUM_REGS:1 selector over the flattened storage image
  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (raddr == ADDR_W'(i)) begin
        sel_word = mem_flat[word_lo(i, DATA_W) +: DATA_W];
      end
    end
  end

  // Forward an accepted same-cycle write; register 0 overrides everything
  always_comb begin
    rdata = sel_word;
    if ((BYPASS != 0) && byp_en && (raddr == waddr)) begin
      rdata = wdata;
    end
    if ((ZERO_REG != 0) && (raddr == '0)) begin
      rdata = '0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised multi-port register file with sequenced clear
module regfile_mp
  import rf_pkg::*;
#(
  parameter int  DATA_W     = 32,
  parameter int  NUM_REGS   = 32,
  parameter int  NUM_RD     = 2,
  parameter int  RD_LATENCY = 0,
  parameter int  BYPASS     = 1,
  parameter int  ZERO_REG   = 1,
  localparam int ADDR_W     = clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  input  logic                     clr_req,
  output logic                     busy,
  output logic                     wr_drop
);

  rf_state_e                        state_q, state_d;
  logic [ADDR_W-1:0]                cnt_q, cnt_d;
  logic [NUM_REGS-1:0][DATA_W-1:0]  mem_q;
  logic [NUM_REGS*DATA_W-1:0]       mem_flat;
  logic [NUM_RD*DATA_W-1:0]         rdata_d;
  logic                             wr_ok;

  assign busy     = (state_q == ST_CLEAR);
  assign wr_drop  = we && busy;
  // An external write lands only when the clear engine is idle and it
  // does not target the hardwired zero register.
  assign wr_ok    = we && !busy && !((ZERO_REG != 0) && (waddr == '0));
  assign mem_flat = mem_q;

  // Clear engine state and sweep counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Clear engine next state: sweep every register once, then go idle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ADDR_W'(NUM_REGS - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Storage: the clear sweep owns the write path while busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
    end else if (busy) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_ok) begin
      mem_q[waddr] <= wdata;
    end
  end

  // One selector per read port
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    rf_read_port #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W),
      .BYPASS   (BYPASS),
      .ZERO_REG (ZERO_REG)
    ) u_rd (
      .mem_flat (mem_flat),
      .raddr    (raddr[slice_lo(k, ADDR_W) +: ADDR_W]),
      .byp_en   (wr_ok),
      .waddr    (waddr),
      .wdata    (wdata),
      .rdata    (rdata_d[slice_lo(k, DATA_W) +: DATA_W])
    );
  end

  if (RD_LATENCY == 1) begin : g_rd_reg
    logic [NUM_RD*DATA_W-1:0] rdata_q;

    // Registered read: present this cycle's selection on the next cycle
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdata_q <= '0;
      end else begin
        rdata_q <= rdata_d;
      end
    end

    assign rdata = rdata_q;
  end else begin : g_rd_comb
    assign rdata = rdata_d;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - scoreboard bench for regfile_mp against a behavioural model
module tb_regfile_mp;

  localparam int DW0 = 32, NR0 = 32, NP0 = 2, AW0 = 5;
  localparam int DW1 = 16, NR1 = 16, NP1 = 4, AW1 = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                 we0 = 0, clr0 = 0, busy0, drop0;
  logic [AW0-1:0]       waddr0 = '0;
  logic [DW0-1:0]       wdata0 = '0;
  logic [NP0*AW0-1:0]   raddr0 = '0;
  logic [NP0*DW0-1:0]   rdata0;

  logic                 we1 = 0, clr1 = 0, busy1, drop1;
  logic [AW1-1:0]       waddr1 = '0;
  logic [DW1-1:0]       wdata1 = '0;
  logic [NP1*AW1-1:0]   raddr1 = '0;
  logic [NP1*DW1-1:0]   rdata1;

  regfile_mp #(.DATA_W(DW0), .NUM_REGS(NR0), .NUM_RD(NP0), .RD_LATENCY(0),
               .BYPASS(1), .ZERO_REG(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .we(we0), .waddr(waddr0), .wdata(wdata0),
    .raddr(raddr0), .rdata(rdata0), .clr_req(clr0), .busy(busy0), .wr_drop(drop0));

  regfile_mp #(.DATA_W(DW1), .NUM_REGS(NR1), .NUM_RD(NP1), .RD_LATENCY(1),
               .BYPASS(0), .ZERO_REG(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .we(we1), .waddr(waddr1), .wdata(wdata1),
    .raddr(raddr1), .rdata(rdata1), .clr_req(clr1), .busy(busy1), .wr_drop(drop1));

  typedef struct {
    longint      due;
    logic [63:0] rd;
    logic        busy;
    logic        drop;
    bit          has_rd;
    bit          has_flags;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   busy_cycles = 0;

  // Reference state: plain arrays plus a clear sweep position
  logic [DW0-1:0] m0 [NR0];
  logic [DW1-1:0] m1 [NR1];
  bit             clr_act = 0;
  int             clr_idx = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [DW0-1:0] ref_read0(input int a);
    if (a == 0) return '0;
    if (we0 && !clr_act && (a == int'(waddr0))) return wdata0;
    return m0[a];
  endfunction

  function automatic logic [DW1-1:0] ref_read1(input int a);
    return m1[a];
  endfunction

  task automatic push_expect();
    exp_t e;
    e = '{due: $time + 2, rd: '0, busy: clr_act, drop: we0 && clr_act, has_rd: 1, has_flags: 1};
    for (int k = 0; k < NP0; k++) e.rd[k*DW0 +: DW0] = ref_read0(int'(raddr0[k*AW0 +: AW0]));
    q0.push_back(e);
    e = '{due: $time + 2, rd: '0, busy: 1'b0, drop: 1'b0, has_rd: 0, has_flags: 1};
    q1.push_back(e);
    e = '{due: $time + 12, rd: '0, busy: 1'b0, drop: 1'b0, has_rd: 1, has_flags: 0};
    for (int k = 0; k < NP1; k++) e.rd[k*DW1 +: DW1] = ref_read1(int'(raddr1[k*AW1 +: AW1]));
    q1.push_back(e);
  endtask

  // Record expectations for the current inputs, advance the model across the edge
  task automatic issue();
    push_expect();
    if (clr_act) begin
      m0[clr_idx] = '0;
      clr_idx++;
      if (clr_idx == NR0) clr_act = 0;
    end else begin
      if (we0 && waddr0 != 0) m0[waddr0] = wdata0;
      if (clr0) begin
        clr_act = 1;
        clr_idx = 0;
      end
    end
    if (we1) m1[waddr1] = wdata1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    exp_t e;
    rst_n = 0; we0 = 0; clr0 = 0; we1 = 0; clr1 = 0;
    for (int i = 0; i < NR0; i++) m0[i] = '0;
    for (int i = 0; i < NR1; i++) m1[i] = '0;
    clr_act = 0;
    clr_idx = 0;
    q1.delete();
    e = '{due: $time + 2, rd: '0, busy: 1'b0, drop: 1'b0, has_rd: 1, has_flags: 1};
    for (int k = 0; k < NP0; k++) e.rd[k*DW0 +: DW0] = ref_read0(int'(raddr0[k*AW0 +: AW0]));
    q0.push_back(e);
    e = '{due: $time + 2, rd: '0, busy: 1'b0, drop: 1'b0, has_rd: 1, has_flags: 1};
    q1.push_back(e);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic idle();
    we0 = 0; clr0 = 0; we1 = 0;
  endtask

  task automatic rd0(input int p0, input int p1);
    raddr0[0 +: AW0]   = AW0'(p0);
    raddr0[AW0 +: AW0] = AW0'(p1);
  endtask

  task automatic rd1_all(input int a);
    for (int k = 0; k < NP1; k++) raddr1[k*AW1 +: AW1] = AW1'(a);
  endtask

  // Monitor: compare whatever expectations fall due at this sample point
  always @(negedge clk) begin
    exp_t e;
    #2;
    while (q0.size() > 0 && q0[0].due <= $time) begin
      e = q0.pop_front();
      if (e.due != $time) begin
        n_checks++; n_fail++;
        $display("FAIL dut0_stale due %0d now %0t", e.due, $time);
      end else begin
        check("dut0_rdata", rdata0, e.rd);
        check("dut0_busy", busy0, e.busy);
        check("dut0_wr_drop", drop0, e.drop);
      end
    end
    while (q1.size() > 0 && q1[0].due <= $time) begin
      e = q1.pop_front();
      if (e.due != $time) begin
        n_checks++; n_fail++;
        $display("FAIL dut1_stale due %0d now %0t", e.due, $time);
      end else begin
        if (e.has_rd) check("dut1_rdata", rdata1, e.rd);
        if (e.has_flags) begin
          check("dut1_busy", busy1, e.busy);
          check("dut1_wr_drop", drop1, e.drop);
        end
      end
    end
  end

  always @(negedge clk) begin
    #3;
    if (busy0 === 1'b1) busy_cycles++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    do_reset();

    // r5 write then read; r6 untouched reads 0
    idle(); we0 = 1; waddr0 = 5; wdata0 = 32'hDEADBEEF; rd0(5, 6);
    issue();
    idle(); rd0(5, 6);
    issue();

    // same-cycle forwarding on dut0; dut1 has none and shows the old value
    idle(); we0 = 1; waddr0 = 7; wdata0 = 32'h12345678; rd0(7, 7);
    we1 = 1; waddr1 = 7; wdata1 = 16'h5678; rd1_all(7);
    issue();
    idle(); rd0(7, 7); rd1_all(7);
    issue();

    // zero register: dut0 ignores writes to r0, dut1 stores them
    idle(); we0 = 1; waddr0 = 0; wdata0 = 32'hFFFFFFFF;
    we1 = 1; waddr1 = 0; wdata1 = 16'hFFFF;
    issue();
    idle(); rd0(0, 0); rd1_all(0);
    issue();

    // registered read latency on dut1
    idle(); we1 = 1; waddr1 = 2; wdata1 = 16'h1111;
    issue();
    idle(); rd1_all(2);
    issue();
    idle(); rd1_all(3);
    issue();

    // fill, then clear with a dropped write and a repeated request mid-clear
    for (int i = 0; i < NR0; i++) begin
      idle(); we0 = 1; waddr0 = AW0'(i); wdata0 = i + 1; rd0(i, (i + 31) % 32);
      issue();
    end
    idle(); clr0 = 1; rd0(4, 30);
    busy_cycles = 0;
    issue();
    for (int c = 0; c < NR0 + 3; c++) begin
      idle(); rd0(c % 32, 31 - (c % 32));
      if (c == 3) begin we0 = 1; waddr0 = 3; wdata0 = 32'hBAD0BAD0; end
      if (c == 10) clr0 = 1;
      issue();
    end
    check("busy_cycle_count", busy_cycles, NR0);
    for (int i = 0; i < NR0; i += 2) begin
      idle(); rd0(i, i + 1);
      issue();
    end

    // write and clear request together in IDLE
    idle(); we0 = 1; waddr0 = 4; wdata0 = 32'h0BADF00D; clr0 = 1; rd0(4, 4);
    issue();
    for (int c = 0; c < NR0 + 2; c++) begin
      idle(); rd0(4, c % 32);
      issue();
    end

    // reset in the middle of a clear
    for (int i = 1; i < NR0; i++) begin
      idle(); we0 = 1; waddr0 = AW0'(i); wdata0 = 32'hC0DE0000 + i;
      issue();
    end
    idle(); clr0 = 1;
    issue();
    for (int c = 0; c < 10; c++) begin
      idle(); rd0(c, 31 - c);
      issue();
    end
    rd0(9, 20);
    do_reset();
    for (int i = 0; i < NR0; i += 2) begin
      idle(); rd0(i, i + 1); rd1_all(i % NR1);
      issue();
    end
    idle(); we0 = 1; waddr0 = 9; wdata0 = 32'hA5A5A5A5;
    issue();
    idle(); rd0(9, 8);
    issue();

    // randomized traffic on both instances
    for (int n = 0; n < 400; n++) begin
      we0 = 1'($urandom_range(0, 1));
      waddr0 = AW0'($urandom);
      wdata0 = $urandom;
      raddr0 = (NP0*AW0)'($urandom);
      if ($urandom_range(0, 3) == 0) raddr0[0 +: AW0] = waddr0;
      clr0 = ($urandom_range(0, 79) == 0);
      we1 = 1'($urandom_range(0, 1));
      waddr1 = AW1'($urandom);
      wdata1 = DW1'($urandom);
      raddr1 = (NP1*AW1)'($urandom);
      issue();
    end

    idle();
    issue();
    issue();
    #5;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file replacing the fixed 32x32 single-read selector in the datapath decode stage. It holds NUM_REGS words of DATA_W bits, serves NUM_RD independent read ports, and accepts one write per cycle. It also provides optional write-to-read bypass, an optional hardwired zero register, a selectable read latency, and a sequenced clear engine that zeroes the whole file without a reset.

## Interface

Parameters:
- DATA_W, 32, word width in bits
- NUM_REGS, 32, number of registers; power of two, 2..64
- NUM_RD, 2, number of read ports, 1..4
- RD_LATENCY, 0, read latency: 0 = combinational read, 1 = registered read
- BYPASS, 1, 1 = a same-cycle write is forwarded to a matching read
- ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes

Ports (ADDR_W = clog2(NUM_REGS)):
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- we  in  1  write enable
- waddr  in  ADDR_W  write address
- wdata  in  DATA_W  write data
- raddr  in  NUM_RD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W]
- rdata  out  NUM_RD*DATA_W  read data; port k occupies bits [k*DATA_W +: DATA_W]
- clr_req  in  1  single-cycle pulse that starts a full clear
- busy  out  1  clear engine active
- wr_drop  out  1  one-cycle pulse: the write presented this cycle was discarded

## Operation

- Write: if we=1, busy=0 and (ZERO_REG=0 or waddr!=0), mem[waddr] takes wdata at the rising edge.
- Read, port k: the value is mem[raddr_k].
  - If ZERO_REG=1 and raddr_k=0, the value is 0.
  - If BYPASS=1, we=1, busy=0, raddr_k=waddr and the write is not to the zero register, the value is wdata. This is same-cycle forwarding.
- RD_LATENCY=0: rdata is combinational from the current-cycle addresses.
- RD_LATENCY=1: rdata is registered; it shows the value computed from the previous cycle's addresses, bypass included.
- Clear engine states:
  - IDLE: busy=0. clr_req=1 moves to CLEAR and loads cnt=0.
  - CLEAR: busy=1. Each cycle writes mem[cnt]=0 and increments cnt. When cnt=NUM_REGS-1, that register is written and the engine returns to IDLE.
- A clear takes exactly NUM_REGS cycles with busy=1.
- clr_req while busy=1 is ignored and does not restart the count.
- During CLEAR:
  - External writes are discarded and wr_drop=1 for each such cycle with we=1.
  - Bypass is disabled.
  - Reads return current contents, so they may show a partially cleared file.
- Simultaneous clr_req=1 and we=1 in IDLE: the write completes, and CLEAR begins the next cycle. That write is later overwritten with 0.
- Reset (rst_n=0, any time, including mid-clear):
  - All mem entries go to 0.
  - State goes to IDLE and cnt to 0.
  - busy=0 and wr_drop=0.
  - Registered rdata goes to 0.

## Timing

- Write latency: 1 edge. Without bypass, a read in the next cycle sees the new data.
- Read latency: 0 or 1 cycle per RD_LATENCY.
- busy asserts the cycle after clr_req is sampled and stays high for NUM_REGS cycles.
- wr_drop is combinational from we and busy.
- Reset-release: first write accepted on the first rising edge with rst_n=1.

## Structure

- Package rf_pkg holds:
  - the clog2 function
  - the state encoding (IDLE=1'b0, CLEAR=1'b1)
  - the port-slice index helpers
- Sub-module rf_read_port: one NUM_REGS:1 DATA_W-wide selector plus the zero and bypass logic. It is instantiated NUM_RD times in a generate loop and is the direct parametrised successor of the per-bit mux tree.
- The top level owns the storage array, the write logic, the clear FSM and the optional output register.

## Test plan

- Reset, then write 0xDEADBEEF to r5. With RD_LATENCY=0, reading r5 on port 0 in the next cycle returns 0xDEADBEEF, and port 1 reading r6 returns 0.
- BYPASS=1: in the same cycle, write 0x12345678 to r7 and read r7 on both ports. Both return 0x12345678 that cycle. With BYPASS=0, both return the old value (0).
- ZERO_REG=1: write 0xFFFFFFFF to r0; a later read of r0 returns 0. With ZERO_REG=0, the read returns 0xFFFFFFFF.
- Fill all registers with index+1, then pulse clr_req.
  - busy is high for exactly 32 cycles.
  - A write to r3 during busy raises wr_drop and has no effect.
  - After busy falls, all reads return 0.
  - A second clr_req mid-clear does not extend busy.
- Drop rst_n at cycle 10 of a clear: busy=0 immediately, all registers read 0, and a subsequent write and read of r9=0xA5A5A5A5 succeeds.
- RD_LATENCY=1, NUM_RD=4, NUM_REGS=16, DATA_W=16: write r2=0x1111, then read r2 on all ports. The data appears exactly one cycle after the address is presented.
